// File: rtl/snes_pkg.sv
// Shared SNES joypad definitions: button bit positions, frame length and the
// responder FSM state encoding.
package snes_pkg;

  // Button positions inside the 16-bit button word (pressed = 1).
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // Number of real buttons; positions at and above this always read unpressed.
  localparam int SNES_NUM_BUTTONS = 12;

  // Bits shifted out per latch/clock frame.
  localparam int SNES_NUM_BITS = 16;

  // Responder frame state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } snes_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with single-cycle
// rise/fall pulses derived from the synchronised level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign rise = chain[SYNC_STAGES-1] & ~prev;
  assign fall = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/snes_controller_responder.sv
// Device end of the SNES joypad latch/clock/data protocol: synchronises the
// host's latch and clock and serially presents the (active-low) button word.
module snes_controller_responder
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   NUM_BITS    = SNES_NUM_BITS,
  parameter logic TAIL_LEVEL  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] button_state,
  input  logic        controller_latch,
  input  logic        controller_clock,
  output logic        controller_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BITS - 1);

  logic latch_rise;
  logic latch_fall;
  logic clk_rise;
  logic clk_fall_unused;

  snes_state_t         state;
  snes_state_t         state_n;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] shreg_n;
  logic [NUM_BITS-1:0] load_word;
  logic [CW-1:0]       bit_count;
  logic [CW-1:0]       count_n;
  logic                data_n;
  logic                done_n;
  logic                busy_n;
  logic                unused_buttons;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clock    (clock),
    .reset    (reset),
    .async_in (controller_latch),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clock    (clock),
    .reset    (reset),
    .async_in (controller_clock),
    .rise     (clk_rise),
    .fall     (clk_fall_unused)
  );

  // The upper button bits carry no buttons and never reach the line.
  assign unused_buttons = &button_state[15:SNES_NUM_BUTTONS];

  // Line-level load word: inverted buttons, non-button positions held high.
  always_comb begin
    load_word = '1;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (i < SNES_NUM_BUTTONS) begin
        load_word[i] = ~button_state[i];
      end else begin
        load_word[i] = 1'b1;
      end
    end
  end

  // Next-state, shift-register and output decode; latch rise overrides all.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    count_n = bit_count;
    done_n  = 1'b0;
    if (latch_rise) begin
      state_n = ST_LOAD;
      shreg_n = load_word;
      count_n = '0;
    end else begin
      case (state)
        ST_LOAD: begin
          // Keep reloading so the word at latch fall is the one sent.
          shreg_n = load_word;
          if (latch_fall) begin
            state_n = ST_SHIFT;
            count_n = '0;
          end else begin
            state_n = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            shreg_n = {1'b1, shreg[NUM_BITS-1:1]};
            count_n = bit_count + CW'(1);
            // The edge seen while the last bit is on the line ends the frame.
            if (bit_count == LAST_IDX) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else begin
              state_n = ST_SHIFT;
            end
          end else begin
            state_n = ST_SHIFT;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_n = state;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    if ((state_n == ST_LOAD) || (state_n == ST_SHIFT)) begin
      data_n = shreg_n[0];
    end else begin
      data_n = TAIL_LEVEL;
    end
    busy_n = (state_n == ST_SHIFT);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      shreg           <= '1;
      bit_count       <= '0;
      controller_data <= TAIL_LEVEL;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_n;
      shreg           <= shreg_n;
      bit_count       <= count_n;
      controller_data <= data_n;
      frame_done      <= done_n;
      busy            <= busy_n;
    end
  end

endmodule

// File: tb/tb_snes_controller_responder.sv
// Self-checking bench for snes_controller_responder: a frame-level reference
// model checked every cycle, plus host-level frame reads with literal results.
module tb_snes_controller_responder;
  import snes_pkg::*;

  localparam int   S    = 2;
  localparam logic TAIL = 1'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] button_state = 16'h0000;
  logic        controller_latch = 1'b0;
  logic        controller_clock = 1'b1;
  logic        controller_data;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  snes_controller_responder #(
    .SYNC_STAGES (S),
    .NUM_BITS    (16),
    .TAIL_LEVEL  (TAIL)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .button_state     (button_state),
    .controller_latch (controller_latch),
    .controller_clock (controller_clock),
    .controller_data  (controller_data),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always #15 clock = ~clock;

  // Comparison helper shared by the compare process and the directed tests.
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pin history (index 0 = value taken at this edge); an edge is acted on
  // once it has travelled S+1 samples down the history.
  logic [S+1:0] lh = '0;
  logic [S+1:0] ch = '0;
  int           m_state = 0;   // 0 idle, 1 latching, 2 sending, 3 finished
  int           m_idx = 0;     // index of the bit currently on the line
  logic [15:0]  m_word = 16'hFFFF;
  logic         exp_data = TAIL;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;

  function automatic logic [15:0] line_word(input logic [15:0] b);
    return {4'hF, ~b[11:0]};
  endfunction

  always @(posedge clock) begin
    logic lr, lf, cr;
    if (reset) begin
      lh = '0; ch = '0;
      m_state = 0; m_idx = 0;
      exp_data = TAIL; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      lh = {lh[S:0], controller_latch};
      ch = {ch[S:0], controller_clock};
      lr = lh[S] & ~lh[S+1];
      lf = ~lh[S] & lh[S+1];
      cr = ch[S] & ~ch[S+1];
      exp_done = 1'b0;
      if (lr) begin
        m_state = 1; m_word = line_word(button_state);
      end else if (m_state == 1) begin
        m_word = line_word(button_state);
        if (lf) begin m_state = 2; m_idx = 0; end
      end else if (m_state == 2 && cr) begin
        if (m_idx == 15) begin m_state = 3; exp_done = 1'b1; end
        else m_idx++;
      end
      exp_data = (m_state == 1) ? m_word[0] :
                 (m_state == 2) ? m_word[m_idx] : TAIL;
      exp_busy = (m_state == 2);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("data", {31'd0, controller_data}, {31'd0, exp_data});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    end
  end

  // Count observed frame_done pulses.
  always @(posedge clock) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- host stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Host-side frame: latch pulse, then nclk clock pulses; host samples the
  // line just before each falling clock edge.
  task automatic send_frame(input int nclk, input int hl, input bit do_chg,
                            input logic [15:0] chg, output logic [15:0] got);
    controller_latch = 1'b1;
    cyc(2 * hl);
    controller_latch = 1'b0;
    cyc(hl);
    if (do_chg) button_state = chg;
    got = 16'hFFFF;
    for (int k = 0; k < nclk; k++) begin
      if (k < 16) got[k] = controller_data;
      controller_clock = 1'b0;
      cyc(hl);
      controller_clock = 1'b1;
      cyc(hl);
    end
    cyc(6);
  endtask

  task automatic toggle_clk(input int n);
    for (int k = 0; k < n; k++) begin
      controller_clock = 1'b0; cyc(5);
      controller_clock = 1'b1; cyc(5);
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] b;
    int d0, nclk, hl;
    bit chg;

    cyc(2);
    chk_en = 1'b1;
    cyc(3);
    reset = 1'b0;

    // Idle: clock activity alone changes nothing.
    cyc(20);
    toggle_clk(8);
    check("idle_data", {31'd0, controller_data}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done_cnt", done_cnt, 32'd0);

    // B + A pressed.
    button_state = 16'h0101;
    d0 = done_cnt;
    send_frame(16, 10, 1'b0, 16'h0000, got);
    check("frame_0101", {16'd0, got}, {16'd0, 16'hFEFE});
    check("frame_0101_done", done_cnt - d0, 32'd1);
    check("tail_data", {31'd0, controller_data}, 32'd0);
    check("tail_busy", {31'd0, busy}, 32'd0);

    // Unused bits never show as pressed.
    button_state = 16'hF000;
    send_frame(16, 8, 1'b0, 16'h0000, got);
    check("frame_F000", {16'd0, got}, {16'd0, 16'hFFFF});

    // Buttons change after latch fall: frame keeps the latched word.
    button_state = 16'h0001;
    send_frame(16, 7, 1'b1, 16'h0002, got);
    check("frame_hold", {16'd0, got}, {16'd0, 16'hFFFE});

    // Abort after 5 edges, then a fresh frame from bit 0.
    button_state = 16'h0ABC;
    d0 = done_cnt;
    send_frame(5, 6, 1'b0, 16'h0000, got);
    check("abort_busy", {31'd0, busy}, 32'd1);
    button_state = 16'h0030;
    send_frame(16, 6, 1'b0, 16'h0000, got);
    check("frame_after_abort", {16'd0, got}, {16'd0, 16'hFFCF});
    check("abort_done_cnt", done_cnt - d0, 32'd1);

    // Reset mid-frame after 8 edges.
    button_state = 16'h0F0F;
    d0 = done_cnt;
    send_frame(8, 6, 1'b0, 16'h0000, got);
    check("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    cyc(1);
    check("rst_data", {31'd0, controller_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    toggle_clk(10);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_data", {31'd0, controller_data}, 32'd0);
    check("post_rst_done", done_cnt - d0, 32'd0);

    // Randomised frames, including partial, overlong and changed buttons.
    for (int it = 0; it < 25; it++) begin
      b = 16'($urandom);
      button_state = b;
      nclk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 16;
      hl = $urandom_range(5, 12);
      chg = ($urandom_range(0, 1) == 1);
      d0 = done_cnt;
      send_frame(nclk, hl, chg, 16'($urandom), got);
      if (nclk >= 16) begin
        check("rand_frame", {16'd0, got}, {16'd0, line_word(b)});
        check("rand_done", done_cnt - d0, 32'd1);
      end else begin
        check("rand_partial_done", done_cnt - d0, 32'd0);
      end
    end

    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
